axis_pkt_arbiter: RTL and testbench

//  Packet-level round-robin arbiter sharing one AXI4-Stream processing engine between
//  NUM_SRC AXI4-Stream sources. Grant locks per packet (until TLAST). Beat cap MAX_BEATS

---
 rtl/axis_pkt_arbiter.sv | 143 ++++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter: NUM_SRC AXI4-Stream sources share one engine port.
// The grant locks for a whole packet, and packets are split at MAX_BEATS beats.
module axis_pkt_arbiter #(
  parameter int NUM_SRC            = 4,
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_BEATS          = 8,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                                   AXIS_ACLK,
  input  logic                                   AXIS_ARESETN,
  input  logic [NUM_SRC-1:0]                     S_AXIS_TVALID,
  output logic [NUM_SRC-1:0]                     S_AXIS_TREADY,
  input  logic [NUM_SRC*C_AXIS_TDATA_WIDTH-1:0]  S_AXIS_TDATA,
  input  logic [NUM_SRC*C_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic [NUM_SRC-1:0]                     S_AXIS_TLAST,
  output logic                                   M_AXIS_TVALID,
  input  logic                                   M_AXIS_TREADY,
  output logic [C_AXIS_TDATA_WIDTH-1:0]          M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]        M_AXIS_TSTRB,
  output logic                                   M_AXIS_TLAST,
  output logic [$clog2(NUM_SRC)-1:0]             grant_idx,
  output logic                                   busy,
  output logic [CNT_WIDTH-1:0]                   pkt_count
);

  localparam int W      = C_AXIS_TDATA_WIDTH;
  localparam int SW     = C_AXIS_TDATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_SRC);
  localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [IDX_W-1:0]   grant_r;
  logic [IDX_W-1:0]   grant_s;
  logic [BEAT_W-1:0]  beat_cnt_r;
  logic [CNT_WIDTH-1:0] pkt_count_r;
  logic               send_s;
  logic               xfer_s;
  logic               pkt_done_s;

  // First requester after 'last', wrapping modulo NUM_SRC; 'last' itself is checked last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = last;
    found = 1'b0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      idx   = (int'(last) + off) % NUM_SRC;
      pick  = (!found && req[idx]) ? IDX_W'(idx) : pick;
      found = found | req[idx];
    end
    return pick;
  endfunction

  // State and grant register
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_r <= IDLE;
      grant_r <= IDX_W'(NUM_SRC - 1);
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
    end
  end

  // Next-state and arbitration decision
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    case (state_r)
      IDLE: begin
        if (|S_AXIS_TVALID) begin
          state_s = SEND;
          grant_s = rr_pick(S_AXIS_TVALID, grant_r);
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (pkt_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Zero-latency steering; everything is held quiet during reset and in IDLE
  always_comb begin
    send_s        = AXIS_ARESETN && (state_r == SEND);
    M_AXIS_TDATA  = S_AXIS_TDATA[int'(grant_r)*W +: W];
    M_AXIS_TSTRB  = S_AXIS_TSTRB[int'(grant_r)*SW +: SW];
    if (send_s) begin
      M_AXIS_TVALID = S_AXIS_TVALID[grant_r];
      M_AXIS_TLAST  = S_AXIS_TLAST[grant_r] | (beat_cnt_r == LAST_BEAT);
      S_AXIS_TREADY = NUM_SRC'(M_AXIS_TREADY) << grant_r;
    end else begin
      M_AXIS_TVALID = 1'b0;
      M_AXIS_TLAST  = 1'b0;
      S_AXIS_TREADY = {NUM_SRC{1'b0}};
    end
    xfer_s     = M_AXIS_TVALID & M_AXIS_TREADY;
    pkt_done_s = xfer_s & M_AXIS_TLAST;
  end

  // Beat counter drives the forced TLAST; packet counter wraps naturally
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      beat_cnt_r  <= {BEAT_W{1'b0}};
      pkt_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (state_r == IDLE || pkt_done_s) begin
        beat_cnt_r <= {BEAT_W{1'b0}};
      end else if (xfer_s) begin
        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
      if (pkt_done_s) begin
        pkt_count_r <= pkt_count_r + CNT_WIDTH'(1);
      end else begin
        pkt_count_r <= pkt_count_r;
      end
    end
  end

  assign grant_idx = grant_r;
  assign busy      = (state_r == SEND);
  assign pkt_count = pkt_count_r;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench for axis_pkt_arbiter: per-source expected-beat queues are filled as
// beats are presented and drained by an output monitor that models the beat cap and counter.
module tb_axis_pkt_arbiter;
  localparam int NS = 4;
  localparam int W  = 32;
  localparam int SW = W / 8;
  localparam int MB = 8;
  localparam int CW = 4;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic          l;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic [NS-1:0]    s_tvalid, s_tready, s_tlast;
  logic [NS*W-1:0]  s_tdata;
  logic [NS*SW-1:0] s_tstrb;
  logic             m_tvalid, m_tready, m_tlast;
  logic [W-1:0]     m_tdata;
  logic [SW-1:0]    m_tstrb;
  logic [1:0]       grant_idx;
  logic             busy;
  logic [CW-1:0]    pkt_count;

  logic          src_valid [NS];
  logic [W-1:0]  src_data  [NS];
  logic [SW-1:0] src_strb  [NS];
  logic          src_last  [NS];

  beat_t exp_q [NS][$];
  int    obs_src_q[$];
  int    obs_len_q[$];
  int    total = 0;
  int    bad = 0;
  int    mon_beat = 0;
  int    mon_src = 0;
  int    exp_cnt = 0;
  bit    abort = 1'b0;
  bit    rand_rdy = 1'b0;

  axis_pkt_arbiter #(
    .NUM_SRC(NS), .C_AXIS_TDATA_WIDTH(W), .MAX_BEATS(MB), .CNT_WIDTH(CW)
  ) dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready), .S_AXIS_TDATA(s_tdata),
    .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TLAST(s_tlast),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TDATA(m_tdata),
    .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TLAST(m_tlast),
    .grant_idx(grant_idx), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tstrb  = '0;
    for (int i = 0; i < NS; i++) begin
      s_tvalid[i]          = src_valid[i];
      s_tlast[i]           = src_last[i];
      s_tdata[i*W +: W]    = src_data[i];
      s_tstrb[i*SW +: SW]  = src_strb[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Engine-side ready: always 1, or a coin toss per cycle
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  task automatic mon_xfer();
    int    src;
    beat_t e;
    logic  exp_last;
    src = int'(m_tdata[W-1:W-8]);
    check("beat_queued", 64'(src < NS && exp_q[src].size() > 0), 64'(1));
    if (src < NS && exp_q[src].size() > 0) begin
      e = exp_q[src].pop_front();
      exp_last = e.l | (mon_beat == MB - 1);
      check("m_tdata", 64'(m_tdata), 64'(e.d));
      check("m_tstrb", 64'(m_tstrb), 64'(e.s));
      check("m_tlast", 64'(m_tlast), 64'(exp_last));
      check("grant_idx", 64'(grant_idx), 64'(src));
      check("busy_xfer", 64'(busy), 64'(1));
      check("pkt_count_run", 64'(pkt_count), 64'(exp_cnt));
      if (mon_beat > 0) check("no_interleave", 64'(src), 64'(mon_src));
      else mon_src = src;
      if (exp_last) begin
        obs_src_q.push_back(src);
        obs_len_q.push_back(mon_beat + 1);
        mon_beat = 0;
        exp_cnt  = (exp_cnt + 1) % (1 << CW);
      end else begin
        mon_beat++;
      end
    end
  endtask

  // Output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy) begin
          check("tready_steer", 64'(s_tready), 64'(4'(m_tready) << grant_idx));
          if (mon_beat > 0) check("grant_hold", 64'(grant_idx), 64'(mon_src));
        end else begin
          check("idle_tready", 64'(s_tready), 64'(0));
          check("idle_mvalid", 64'(m_tvalid), 64'(0));
          check("idle_mlast", 64'(m_tlast), 64'(0));
        end
        if (m_tvalid && m_tready) mon_xfer();
      end
    end
  end

  task automatic drive_pkt(input int src, input int nb, input int base, input int gap_pct);
    bit accepted;
    for (int b = 0; b < nb && !abort; b++) begin
      while (!abort && gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        src_valid[src] = 1'b0;
        @(posedge clk);
        #1;
      end
      if (!abort) begin
        src_data[src]  = {8'(src), 24'(base + b)};
        src_strb[src]  = 4'(base + b + src);
        src_last[src]  = (b == nb - 1);
        src_valid[src] = 1'b1;
        exp_q[src].push_back('{d: src_data[src], s: src_strb[src], l: src_last[src]});
        accepted = 1'b0;
        for (int t = 0; t < 3000 && !accepted && !abort; t++) begin
          @(negedge clk);
          if (rst_n && s_tready[src]) accepted = 1'b1;
          @(posedge clk);
          #1;
        end
        if (!abort) check($sformatf("src%0d_accept", src), 64'(accepted), 64'(1));
      end
    end
    src_valid[src] = 1'b0;
    src_last[src]  = 1'b0;
  endtask

  task automatic src_burst(input int src);
    for (int p = 0; p < 3; p++) drive_pkt(src, $urandom_range(12, 1), 'h400 + src * 'h40 + p * 'h10, 30);
  endtask

  task automatic hit_reset();
    rst_n = 1'b0;
    abort = 1'b1;
    #1;
    check("rst_tready", 64'(s_tready), 64'(0));
    check("rst_mvalid", 64'(m_tvalid), 64'(0));
    check("rst_mlast", 64'(m_tlast), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant", 64'(grant_idx), 64'(NS - 1));
    check("rst_pkt_count", 64'(pkt_count), 64'(0));
    for (int i = 0; i < NS; i++) exp_q[i].delete();
    obs_src_q.delete();
    obs_len_q.delete();
    mon_beat = 0;
    mon_src  = 0;
    exp_cnt  = 0;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    hit_reset();
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) check($sformatf("q%0d_empty", i), 64'(exp_q[i].size()), 64'(0));
  endtask

  // Packet order/length list: nibble i of srcs/lens describes packet i
  task automatic check_order(input string tag, input int n, input logic [31:0] srcs,
                             input logic [31:0] lens);
    check({tag, "_npkts"}, 64'(obs_src_q.size()), 64'(n));
    for (int i = 0; i < n && i < obs_src_q.size(); i++) begin
      check($sformatf("%s_src%0d", tag, i), 64'(obs_src_q[i]), 64'(srcs[4*i +: 4]));
      check($sformatf("%s_len%0d", tag, i), 64'(obs_len_q[i]), 64'(lens[4*i +: 4]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      src_valid[i] = 1'b0;
      src_data[i]  = '0;
      src_strb[i]  = '0;
      src_last[i]  = 1'b0;
    end
    #2;
    hit_reset();

    // 1: single 3-beat packet from source 0
    drive_pkt(0, 3, 'hA0, 0);
    drain();
    check_order("t1", 1, 32'h0, 32'h3);
    check("t1_grant", 64'(grant_idx), 64'(0));
    check("t1_pkt_count", 64'(pkt_count), 64'(1));
    check("t1_busy", 64'(busy), 64'(0));

    // 2: all sources requesting -> strict rotation
    apply_reset();
    fork
      begin drive_pkt(0, 2, 'h200, 0); drive_pkt(0, 2, 'h210, 0); end
      drive_pkt(1, 2, 'h220, 0);
      drive_pkt(2, 2, 'h230, 0);
      drive_pkt(3, 2, 'h240, 0);
    join
    drain();
    check_order("t2", 5, 32'h0000_3210, 32'h0002_2222);
    check("t2_pkt_count", 64'(pkt_count), 64'(5));

    // 3: 11-beat packet split at the cap, source 1 slips in between
    apply_reset();
    fork
      drive_pkt(2, 11, 'h300, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        drive_pkt(1, 2, 'h380, 0);
      end
    join
    drain();
    check_order("t3", 3, 32'h0000_0212, 32'h0000_0328);
    check("t3_pkt_count", 64'(pkt_count), 64'(3));

    // 4: random engine backpressure and source gaps
    apply_reset();
    rand_rdy = 1'b1;
    fork
      src_burst(0);
      src_burst(1);
      src_burst(2);
      src_burst(3);
    join
    rand_rdy = 1'b0;
    drain();
    check("t4_pkt_count", 64'(pkt_count), 64'(exp_cnt));

    // 5: reset in the middle of an 8-beat packet
    fork
      drive_pkt(0, 8, 'h500, 0);
      begin
        for (int t = 0; t < 200 && mon_beat < 4; t++) begin
          @(posedge clk);
          #1;
        end
        check("t5_at_beat4", 64'(mon_beat), 64'(4));
        #2;
        hit_reset();
      end
    join
    fork
      drive_pkt(1, 1, 'h5B0, 0);
      drive_pkt(0, 1, 'h5A0, 0);
    join
    drain();
    check_order("t5", 2, 32'h0000_0010, 32'h0000_0011);

    // 6: counter wrap with a 4-bit pkt_count
    apply_reset();
    for (int p = 0; p < 17; p++) drive_pkt(3, 1, 'h600 + p, 0);
    drain();
    check("t6_npkts", 64'(obs_src_q.size()), 64'(17));
    check("t6_pkt_count", 64'(pkt_count), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
